fft32_commutator_ctrl: RTL and testbench

Sequencing controller for the 32-point MDC FFT pipeline (2 samples/cycle, 16 cycles/frame).
- Tracks sample validity through the stage delay lines.
- Drives the per-stage commutator mode word and phase mask, plus global pipeline enable.
- Handles fill, input stalls, back-to-back frames, drain and frame-complete signalling.
- Sits between the input stream interface and the datapath stages 1-4 commutators.

---
 rtl/fft32_ctrl_pkg.sv | 26 ++
 rtl/fft32_commutator_ctrl_if.sv | 23 ++
 rtl/fft32_stage_timer.sv | 30 +++
 rtl/fft32_commutator_ctrl.sv | 81 ++++++++
 tb/tb_fft32_commutator_ctrl.sv | 200 ++++++++++++++++++++
 5 files changed

// File: rtl/fft32_ctrl_pkg.sv
// fft32_ctrl_pkg: shared phase encoding, frame constants and stage-offset helper for the FFT32 controller
package fft32_ctrl_pkg;

    localparam int FRAME_CYC = 16;
    localparam int CNT_W     = $clog2(FRAME_CYC);

    // Inter-stage delay line lengths for stages 1..4 of the MDC pipeline.
    localparam int STAGE_DLY [1:4] = '{8, 4, 2, 1};

    // Enum values double as the com_mask bit position of each phase.
    typedef enum logic [2:0] {
        PH_IDLE  = 3'd0,
        PH_FILL  = 3'd1,
        PH_RUN   = 3'd2,
        PH_DRAIN = 3'd3,
        PH_DONE  = 3'd4
    } phase_t;

    // Valid-pipe tap of stage k (k=5 gives the output tap).
    function automatic int stage_off(input int k, input int bf_lat);
        int off = 1;
        for (int i = 1; i < k; i++) off += STAGE_DLY[i] + bf_lat;
        return off;
    endfunction

endpackage

// File: rtl/fft32_commutator_ctrl_if.sv
// fft32_commutator_ctrl_if: stream/commutator control bundle between source, controller and datapath
// master: drives in_valid, observes controls. slave: controller side.
interface fft32_commutator_ctrl_if;

    logic       in_valid;
    logic       pipe_en;
    logic [4:0] state_com_mode;
    logic [6:0] com_mask;
    logic       out_valid;
    logic       frame_done;
    logic       busy;

    modport master (
        output in_valid,
        input  pipe_en, state_com_mode, com_mask, out_valid, frame_done, busy
    );

    modport slave (
        input  in_valid,
        output pipe_en, state_com_mode, com_mask, out_valid, frame_done, busy
    );

endinterface

// File: rtl/fft32_stage_timer.sv
// fft32_stage_timer: per-stage local counter producing the commutator switch/bypass bit
// Ports: clk, rst (async, active high); active = valid-pipe tap at OFFSET; pipe_en; mode (0=switch, 1=bypass).
module fft32_stage_timer
    import fft32_ctrl_pkg::*;
#(
    parameter int OFFSET  = 1,
    parameter int TOG_BIT = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic active,
    input  logic pipe_en,
    output logic mode
);

    logic [CNT_W-1:0] lc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lc <= '0;
        else if (active & pipe_en) lc <= lc + 1'b1;
    end

    // A stage tapped at offset 0 would precede the first register; it can only bypass.
    if (OFFSET > 0) begin : g_tap
        assign mode = ~(active & lc[TOG_BIT]);
    end else begin : g_none
        assign mode = 1'b1;
    end

endmodule

// File: rtl/fft32_commutator_ctrl.sv
// fft32_commutator_ctrl: sequencing controller for the 32-point MDC FFT pipeline (2 samples/cycle)
// Ports: clk, rst (async, active high); bus (slave): in_valid in; pipe_en, state_com_mode[4:0],
//   com_mask[6:0] (one-hot phase), out_valid, frame_done, busy out.
module fft32_commutator_ctrl
    import fft32_ctrl_pkg::*;
#(
    parameter int BF_LAT = 1
) (
    input logic                    clk,
    input logic                    rst,
    fft32_commutator_ctrl_if.slave bus
);

    localparam int OUT = stage_off(5, BF_LAT);

    phase_t           state;
    logic [OUT:1]     vp;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    logic [4:1]       mode;
    logic             boundary;
    logic             vp_any;
    logic             drain_empty;
    logic             pipe_en;
    logic             out_valid;

    assign boundary    = in_cnt == '0;
    assign vp_any      = |vp;
    // Pipe is empty after this cycle's shift (drain always shifts, no input in that branch).
    assign drain_empty = ~|vp[OUT-1:1];

    // Closing a frame with no new input starts the drain on this very cycle, so the tail
    // never sees a bubble; a mid-frame gap stalls everything.
    assign pipe_en = ~rst & ((state == PH_DRAIN) | bus.in_valid |
                             ((state == PH_FILL || state == PH_RUN) & boundary & vp_any));

    assign out_valid          = vp[OUT] & pipe_en;
    assign bus.pipe_en        = pipe_en;
    assign bus.out_valid      = out_valid;
    assign bus.frame_done     = out_valid & (&out_cnt);
    assign bus.state_com_mode = {mode, 1'b1};
    assign bus.com_mask       = 7'b1 << state;
    assign bus.busy           = state != PH_IDLE;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= PH_IDLE;
            vp      <= '0;
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (pipe_en) vp <= {vp[OUT-1:1], bus.in_valid};
            if (pipe_en & bus.in_valid) in_cnt <= in_cnt + 1'b1;
            if (out_valid) out_cnt <= out_cnt + 1'b1;
            case (state)
                PH_IDLE:  if (bus.in_valid) state <= PH_FILL;
                PH_FILL:  if (boundary & ~bus.in_valid & vp_any) state <= PH_DRAIN;
                          else if (vp[OUT]) state <= PH_RUN;
                PH_RUN:   if (boundary & ~bus.in_valid) state <= PH_DRAIN;
                PH_DRAIN: if (bus.in_valid) state <= PH_RUN;
                          else if (drain_empty) state <= PH_DONE;
                PH_DONE:  state <= bus.in_valid ? PH_FILL : PH_IDLE;
                default:  state <= PH_IDLE;
            endcase
        end
    end

    for (genvar k = 1; k <= 4; k++) begin : g_stage
        fft32_stage_timer #(
            .OFFSET (stage_off(k, BF_LAT)),
            .TOG_BIT(4 - k)
        ) u_timer (
            .clk    (clk),
            .rst    (rst),
            .active (vp[stage_off(k, BF_LAT)]),
            .pipe_en(pipe_en),
            .mode   (mode[k])
        );
    end

endmodule

// File: tb/tb_fft32_commutator_ctrl.sv
// tb_fft32_commutator_ctrl: directed self-checking bench for the FFT32 commutator controller
module tb_fft32_commutator_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_pass = 0;
    int   n_ov, ov_first, ov_last, n_fd;
    int   fd_at [4];

    fft32_commutator_ctrl_if bus ();

    fft32_commutator_ctrl #(.BF_LAT(1)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    endtask

    // Advance one cycle, drive in_valid, and settle before sampling.
    task automatic nxt(input logic v);
        @(posedge clk);
        #1 bus.in_valid = v;
        #2;
    endtask

    task automatic clr();
        n_ov = 0; ov_first = -1; ov_last = -1; n_fd = 0;
        for (int i = 0; i < 4; i++) fd_at[i] = -1;
    endtask

    task automatic tally(input int c);
        if (bus.out_valid) begin
            if (n_ov == 0) ov_first = c;
            ov_last = c;
            n_ov++;
        end
        if (bus.frame_done) begin
            if (n_fd < 4) fd_at[n_fd] = c;
            n_fd++;
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("rst_pe", bus.pipe_en, 1'b0);
        check("rst_mode", bus.state_com_mode, 5'b11111);
        check("rst_mask", bus.com_mask, 7'h01);
        check("rst_busy", bus.busy, 1'b0);

        // Single frame
        clr();
        for (int c = 0; c < 40; c++) begin
            nxt(c < 16);
            tally(c);
            case (c)
                0:  begin check("sf_pe0", bus.pipe_en, 1); check("sf_mode0", bus.state_com_mode, 5'b11111);
                          check("sf_mask0", bus.com_mask, 7'h01); check("sf_busy0", bus.busy, 0); end
                1:  begin check("sf_mask1", bus.com_mask, 7'h02); check("sf_busy1", bus.busy, 1); end
                8:  check("sf_m1_8", bus.state_com_mode[1], 1);
                9:  check("sf_m1_9", bus.state_com_mode[1], 0);
                14: check("sf_mode14", bus.state_com_mode, 5'b11001);
                16: begin check("sf_m1_16", bus.state_com_mode[1], 0); check("sf_mask16", bus.com_mask, 7'h02);
                          check("sf_pe16", bus.pipe_en, 1); end
                17: begin check("sf_m1_17", bus.state_com_mode[1], 1); check("sf_mask17", bus.com_mask, 7'h08);
                          check("sf_m4_17", bus.state_com_mode[4], 1); end
                18: check("sf_m4_18", bus.state_com_mode[4], 1);
                19: check("sf_m4_19", bus.state_com_mode[4], 0);
                20: check("sf_m4_20", bus.state_com_mode[4], 1);
                33: check("sf_m4_33", bus.state_com_mode[4], 0);
                34: check("sf_m4_34", bus.state_com_mode[4], 1);
                35: check("sf_mask35", bus.com_mask, 7'h08);
                36: begin check("sf_mask36", bus.com_mask, 7'h10); check("sf_busy36", bus.busy, 1); end
                37: begin check("sf_mask37", bus.com_mask, 7'h01); check("sf_busy37", bus.busy, 0); end
                default: ;
            endcase
        end
        check("sf_n_ov", n_ov, 16);
        check("sf_ov_first", ov_first, 20);
        check("sf_ov_last", ov_last, 35);
        check("sf_n_fd", n_fd, 1);
        check("sf_fd_at", fd_at[0], 35);

        // Stall of 3 cycles after 5 samples
        clr();
        for (int c = 0; c < 42; c++) begin
            nxt(c < 5 || (c >= 8 && c < 19));
            tally(c);
            case (c)
                4:  check("st_pe4", bus.pipe_en, 1);
                5:  check("st_pe5", bus.pipe_en, 0);
                7:  check("st_pe7", bus.pipe_en, 0);
                8:  check("st_pe8", bus.pipe_en, 1);
                11: check("st_m1_11", bus.state_com_mode[1], 1);
                12: check("st_m1_12", bus.state_com_mode[1], 0);
                19: check("st_m1_19", bus.state_com_mode[1], 0);
                20: check("st_m1_20", bus.state_com_mode[1], 1);
                21: check("st_m4_21", bus.state_com_mode[4], 1);
                22: check("st_m4_22", bus.state_com_mode[4], 0);
                39: check("st_mask39", bus.com_mask, 7'h10);
                40: check("st_mask40", bus.com_mask, 7'h01);
                default: ;
            endcase
        end
        check("st_n_ov", n_ov, 16);
        check("st_ov_first", ov_first, 23);
        check("st_ov_last", ov_last, 38);
        check("st_fd_at", fd_at[0], 38);

        // Three back-to-back frames
        clr();
        for (int c = 0; c < 70; c++) begin
            nxt(c < 48);
            tally(c);
            case (c)
                20: check("bb_mask20", bus.com_mask, 7'h02);
                21: check("bb_mask21", bus.com_mask, 7'h04);
                32: begin check("bb_mask32", bus.com_mask, 7'h04); check("bb_pe32", bus.pipe_en, 1); end
                47: check("bb_mask47", bus.com_mask, 7'h04);
                48: begin check("bb_mask48", bus.com_mask, 7'h04); check("bb_pe48", bus.pipe_en, 1); end
                49: check("bb_mask49", bus.com_mask, 7'h08);
                68: check("bb_mask68", bus.com_mask, 7'h10);
                69: check("bb_mask69", bus.com_mask, 7'h01);
                default: ;
            endcase
        end
        check("bb_n_ov", n_ov, 48);
        check("bb_ov_first", ov_first, 20);
        check("bb_ov_last", ov_last, 67);
        check("bb_n_fd", n_fd, 3);
        check("bb_fd0", fd_at[0], 35);
        check("bb_fd1", fd_at[1], 51);
        check("bb_fd2", fd_at[2], 67);

        // Restart during DRAIN
        clr();
        for (int c = 0; c < 58; c++) begin
            nxt(c < 16 || (c >= 20 && c < 36));
            tally(c);
            case (c)
                18: begin check("rd_pe18", bus.pipe_en, 1); check("rd_mask18", bus.com_mask, 7'h08); end
                20: begin check("rd_mask20", bus.com_mask, 7'h08); check("rd_pe20", bus.pipe_en, 1); end
                21: check("rd_mask21", bus.com_mask, 7'h04);
                39: check("rd_ov39", bus.out_valid, 0);
                40: check("rd_ov40", bus.out_valid, 1);
                56: check("rd_mask56", bus.com_mask, 7'h10);
                57: check("rd_mask57", bus.com_mask, 7'h01);
                default: ;
            endcase
        end
        check("rd_n_ov", n_ov, 32);
        check("rd_ov_last", ov_last, 55);
        check("rd_n_fd", n_fd, 2);
        check("rd_fd1", fd_at[1], 55);

        // Restart on the DONE cycle, then reset mid-RUN
        clr();
        for (int c = 0; c < 60; c++) begin
            nxt(c < 16 || c >= 36);
            tally(c);
            case (c)
                35: check("rn_fd35", bus.frame_done, 1);
                36: begin check("rn_mask36", bus.com_mask, 7'h10); check("rn_pe36", bus.pipe_en, 1);
                          check("rn_busy36", bus.busy, 1); end
                37: begin check("rn_mask37", bus.com_mask, 7'h02); check("rn_busy37", bus.busy, 1); end
                56: begin check("rn_mask56", bus.com_mask, 7'h02); check("rn_ov56", bus.out_valid, 1); end
                57: check("rn_mask57", bus.com_mask, 7'h04);
                default: ;
            endcase
        end
        rst = 1'b1;
        nxt(1'b1);
        check("rr_mask", bus.com_mask, 7'h01);
        check("rr_mode", bus.state_com_mode, 5'b11111);
        check("rr_pe", bus.pipe_en, 0);
        check("rr_ov", bus.out_valid, 0);
        check("rr_fd", bus.frame_done, 0);
        check("rr_busy", bus.busy, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        #2;
        check("rr_pe_rel", bus.pipe_en, 1);
        nxt(1'b0);
        check("rr_mask_fill", bus.com_mask, 7'h02);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
